multicycle_mips_core: RTL and testbench

- Multicycle MIPS-subset core: datapath plus built-in FSM controller behind one shared instruction/data memory port.
- Memory port has a req/ready handshake, so memory latency may vary; a watchdog counter bounds every memory wait.
- Intended replacement for the single-cycle datapath/controller pair. Uses the same ALU control codes: 010 add, 110 sub, 000 and, 001 or, 111 slt.

---
 rtl/multicycle_mips_core.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_mips_core.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mips_core.sv
// Multicycle MIPS-subset core (lw, sw, add, sub, and, or, slt, beq, addi, j)
// with a shared req/ready memory port and a watchdog on every memory wait.
module multicycle_mips_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc_out,
  output logic [3:0]        state_out,
  output logic              instr_done,
  output logic              illegal_instr,
  output logic              bus_error
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t      state, next_state;
  logic [31:0] pc, ir, mdr, a, b, alu_out;
  logic [31:0] rf [32];
  logic [31:0] wait_cnt;
  logic [31:0] addr_full;
  logic        req_int;
  logic [2:0]  alu_ctrl;
  logic        funct_ok;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext;

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign imm_ext = {{16{ir[15]}}, ir[15:0]};

  function automatic logic [31:0] alu(input logic [2:0] ctrl,
                                      input logic [31:0] x,
                                      input logic [31:0] y);
    case (ctrl)
      3'b010:  alu = x + y;
      3'b110:  alu = x - y;
      3'b000:  alu = x & y;
      3'b001:  alu = x | y;
      3'b111:  alu = {31'd0, $signed(x) < $signed(y)};
      default: alu = '0;
    endcase
  endfunction

  always_comb begin
    alu_ctrl = 3'b010;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: alu_ctrl = 3'b010;
      6'b100010: alu_ctrl = 3'b110;
      6'b100100: alu_ctrl = 3'b000;
      6'b100101: alu_ctrl = 3'b001;
      6'b101010: alu_ctrl = 3'b111;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    next_state    = state;
    req_int       = 1'b0;
    mem_we        = 1'b0;
    addr_full     = pc;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      FETCH: begin
        req_int = 1'b1;
        if (mem_ready) next_state = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          OP_RTYPE: begin
            if (funct_ok) begin
              next_state = EXEC;
            end else begin
              illegal_instr = 1'b1;
              next_state    = FETCH;
            end
          end
          default: begin
            illegal_instr = 1'b1;
            next_state    = FETCH;
          end
        endcase
      end
      MEMADR: next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        req_int   = 1'b1;
        addr_full = alu_out;
        if (mem_ready) next_state = MEMWB;
      end
      MEMWR: begin
        req_int   = 1'b1;
        mem_we    = 1'b1;
        addr_full = alu_out;
        if (mem_ready) begin
          instr_done = 1'b1;
          next_state = FETCH;
        end
      end
      EXEC:   next_state = ALUWB;
      ADDIEX: next_state = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: begin
        instr_done = 1'b1;
        next_state = FETCH;
      end
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
    // A request still unanswered on the edge its wait count would reach MAX_WAIT halts the core
    if (MAX_WAIT != 0 && req_int && !mem_ready && (wait_cnt + 32'd1 >= MAX_WAIT))
      next_state = HALT;
  end

  // Gating with reset keeps mem_req low immediately, before any clock edge
  assign mem_req   = req_int & ~reset;
  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_wdata = b;
  assign pc_out    = pc;
  assign state_out = state;
  assign bus_error = (state == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      mdr      <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      wait_cnt <= '0;
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state <= next_state;
      if (req_int) begin
        if (mem_ready) wait_cnt <= '0;
        else           wait_cnt <= wait_cnt + 32'd1;
      end
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        DECODE: begin
          a       <= rf[rs];
          b       <= rf[rt];
          alu_out <= pc + {imm_ext[29:0], 2'b00};
        end
        MEMADR, ADDIEX: alu_out <= a + imm_ext;
        MEMRD: if (mem_ready) mdr <= mem_rdata;
        MEMWB:  if (rt != 5'd0) rf[rt] <= mdr;
        EXEC:   alu_out <= alu(alu_ctrl, a, b);
        ALUWB:  if (rd != 5'd0) rf[rd] <= alu_out;
        ADDIWB: if (rt != 5'd0) rf[rt] <= alu_out;
        BRANCH: if (a == b) pc <= alu_out;
        JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Scoreboard bench for multicycle_mips_core: an ISA-level model predicts every
// memory request and every retirement; a memory responder and monitor compare.
module tb_multicycle_mips_core;

  localparam logic [31:0] RPC     = 32'h0000_0100;
  localparam int unsigned N_INSTR = 300;
  localparam int unsigned K_DIR   = 22;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc_out;
  logic [3:0]  state_out;
  logic        instr_done, illegal_instr, bus_error;

  multicycle_mips_core #(
    .RESET_PC(RPC),
    .ADDR_W  (32),
    .MAX_WAIT(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .pc_out       (pc_out),
    .state_out    (state_out),
    .instr_done   (instr_done),
    .illegal_instr(illegal_instr),
    .bus_error    (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic        illegal;
    int unsigned lat;
  } evt_t;

  logic [31:0] mem [256];
  logic [31:0] mm  [256];
  logic [31:0] rf_m [32];
  req_t        req_q [$];
  evt_t        evt_q [$];

  int unsigned checks = 0, failures = 0;
  int unsigned popped = 0, cyc = 0, last_cyc = 0;
  logic        running = 1'b0, stuck = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_pc;

  logic [31:0] prog [23] = '{
    32'h20010005, 32'h20020007, 32'h00221820, 32'hAC030040,
    32'h8C040040, 32'h2001FFFE, 32'h20020003, 32'h00222822,
    32'h00223024, 32'h00223825, 32'h0022402A, 32'h00220020,
    32'hAC050050, 32'hAC060054, 32'hAC070058, 32'hAC08005C,
    32'hAC000060, 32'hAC040064, 32'hFC000000, 32'h10220005,
    32'h10210001, 32'hFC000000, 32'h080000C0};
  logic [31:0] dir_addr [7] = '{32'h40, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h60, 32'h64};
  logic [31:0] dir_val  [7] = '{32'd12, 32'hFFFF_FFFB, 32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd12};

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [5:0]  fl [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0]  bad [4] = '{6'h3F, 6'h01, 6'h05, 6'h0F};
    logic [4:0]  s, t, d;
    logic [5:0]  fn;
    logic [15:0] imm;
    int unsigned r;
    r = $urandom_range(0, 99);
    s = 5'($urandom_range(0, 7));
    t = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    if (r < 25) begin
      imm = 16'($urandom);
      return {6'b001000, s, t, imm};
    end else if (r < 50) begin
      fn = fl[$urandom_range(0, 4)];
      if ($urandom_range(0, 19) == 0) fn = 6'h3F;
      return {6'b000000, s, t, d, 5'd0, fn};
    end else if (r < 62) begin
      imm = 16'($urandom_range(0, 63) << 2);
      return {6'b100011, s, t, imm};
    end else if (r < 74) begin
      imm = 16'(($urandom_range(0, 63) << 2) | $urandom_range(0, 1));
      return {6'b101011, 5'd0, t, imm};
    end else if (r < 86) begin
      imm = 16'($urandom_range(0, 3));
      return {6'b000100, s, t, imm};
    end else if (r < 94) begin
      return {6'b000010, 26'($urandom_range(32'h58, 32'hFF))};
    end else begin
      return {bad[$urandom_range(0, 3)], 26'($urandom)};
    end
  endfunction

  // ISA-level reference: executes the program instruction by instruction
  task automatic run_model();
    logic [31:0] pc, npc, ir, addr, val, sx;
    logic [5:0]  op, fn;
    logic [4:0]  s, t, d;
    logic        ill;
    int unsigned lat;
    req_t        rq;
    evt_t        ev;
    pc = RPC;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    for (int i = 0; i < 256; i++) mm[i] = mem[i];
    for (int n = 0; n < int'(N_INSTR); n++) begin
      ir = mm[pc[9:2]];
      rq.addr = pc; rq.we = 1'b0; rq.wdata = '0;
      req_q.push_back(rq);
      npc = pc + 32'd4;
      op = ir[31:26]; fn = ir[5:0];
      s = ir[25:21]; t = ir[20:16]; d = ir[15:11];
      sx = {{16{ir[15]}}, ir[15:0]};
      ill = 1'b0; lat = 0; val = '0;
      case (op)
        6'h23: begin
          addr = rf_m[s] + sx;
          rq.addr = addr; rq.we = 1'b0; rq.wdata = '0;
          req_q.push_back(rq);
          if (t != 0) rf_m[t] = mm[addr[9:2]];
          lat = 5;
        end
        6'h2B: begin
          addr = rf_m[s] + sx;
          rq.addr = addr; rq.we = 1'b1; rq.wdata = rf_m[t];
          req_q.push_back(rq);
          mm[addr[9:2]] = rf_m[t];
          lat = 4;
        end
        6'h00: begin
          lat = 4;
          case (fn)
            6'h20:   val = rf_m[s] + rf_m[t];
            6'h22:   val = rf_m[s] - rf_m[t];
            6'h24:   val = rf_m[s] & rf_m[t];
            6'h25:   val = rf_m[s] | rf_m[t];
            6'h2A:   val = ($signed(rf_m[s]) < $signed(rf_m[t])) ? 32'd1 : 32'd0;
            default: ill = 1'b1;
          endcase
          if (!ill && d != 0) rf_m[d] = val;
        end
        6'h04: begin
          if (rf_m[s] == rf_m[t]) npc = npc + (sx << 2);
          lat = 3;
        end
        6'h08: begin
          if (t != 0) rf_m[t] = rf_m[s] + sx;
          lat = 4;
        end
        6'h02: begin
          npc = {npc[31:28], ir[25:0], 2'b00};
          lat = 3;
        end
        default: ill = 1'b1;
      endcase
      if (ill) lat = 2;
      ev.pc = npc; ev.illegal = ill; ev.lat = lat;
      evt_q.push_back(ev);
      pc = npc;
    end
  endtask

  // Memory responder: drives ready/rdata shortly after each rising edge
  req_t        cur;
  logic        busy = 1'b0, has_exp = 1'b0, completing = 1'b0;
  logic        wr_pend;
  logic [31:0] wr_addr, wr_data;
  int unsigned wait_left = 0;

  always @(posedge clk) begin
    #2;
    if (reset) begin
      mem_ready  = 1'b0;
      busy       = 1'b0;
      completing = 1'b0;
    end else begin
      if (completing) begin
        if (wr_pend) mem[wr_addr[9:2]] = wr_data;
        busy = 1'b0;
        completing = 1'b0;
      end
      if (mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          has_exp = 1'b0;
          wait_left = 1000;
          if (!stuck) begin
            if (req_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL req_underflow addr=%h expected=no_request", mem_addr);
            end else begin
              cur = req_q.pop_front();
              has_exp = 1'b1;
              wait_left = (popped >= K_DIR) ? $urandom_range(0, 3) : 0;
            end
          end
        end
        if (has_exp) begin
          check32("req_addr", mem_addr, cur.addr);
          check32("req_we", {31'd0, mem_we}, {31'd0, cur.we});
          if (cur.we) check32("req_wdata", mem_wdata, cur.wdata);
        end
        if (has_exp && wait_left == 0) begin
          mem_ready  = 1'b1;
          mem_rdata  = mem_we ? $urandom : mem[mem_addr[9:2]];
          completing = 1'b1;
          wr_pend    = mem_we;
          wr_addr    = mem_addr;
          wr_data    = mem_wdata;
        end else begin
          mem_ready = 1'b0;
          if (wait_left > 0) wait_left--;
          mem_rdata = $urandom;
        end
      end else begin
        mem_ready = stuck ? 1'b0 : 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Retirement monitor
  evt_t e;
  always @(negedge clk) begin
    if (running) begin
      cyc++;
      if (pend) begin
        check32("pc_after_retire", pc_out, pend_pc);
        pend = 1'b0;
      end
      if (instr_done || illegal_instr) begin
        if (evt_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL evt_underflow done=%b illegal=%b expected=none", instr_done, illegal_instr);
        end else begin
          e = evt_q.pop_front();
          check32("illegal_flag", {31'd0, illegal_instr}, {31'd0, e.illegal});
          check32("done_flag", {31'd0, instr_done}, {31'd0, !e.illegal});
          if (popped < K_DIR) check32("latency", cyc - last_cyc, e.lat);
          last_cyc = cyc;
          pend = 1'b1;
          pend_pc = e.pc;
          popped++;
          if (popped == K_DIR)
            for (int i = 0; i < 7; i++)
              check32("dir_mem", mem[dir_addr[i][9:2]], dir_val[i]);
          if (popped == N_INSTR) stuck = 1'b1;
        end
      end
    end
  end

  int unsigned waits;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = gen_instr();
    for (int i = 0; i < 23; i++) mem[64 + i] = prog[i];
    run_model();

    repeat (2) @(negedge clk);
    check32("rst_pc", pc_out, RPC);
    check32("rst_state", {28'd0, state_out}, 32'd0);
    check32("rst_req", {31'd0, mem_req}, 32'd0);
    check32("rst_bus_error", {31'd0, bus_error}, 32'd0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    running = 1'b1;

    for (int i = 0; i < 40000 && popped < N_INSTR; i++) begin
      @(negedge clk);
      #1;
    end
    if (popped < N_INSTR) begin
      checks++; failures++;
      $display("FAIL retire_timeout retired=%0d expected=%0d", popped, N_INSTR);
      stuck = 1'b1;
    end
    check32("req_q_left", req_q.size(), 32'd0);

    waits = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (bus_error) break;
      if (mem_req) waits++;
    end
    check32("wd_wait_cycles", waits, 32'd4);
    check32("wd_bus_error", {31'd0, bus_error}, 32'd1);
    check32("wd_state", {28'd0, state_out}, 32'd15);
    check32("wd_req", {31'd0, mem_req}, 32'd0);
    repeat (3) @(negedge clk);
    check32("wd_sticky", {28'd0, state_out}, 32'd15);

    running = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check32("arst_pc", pc_out, RPC);
    check32("arst_state", {28'd0, state_out}, 32'd0);
    check32("arst_req", {31'd0, mem_req}, 32'd0);
    check32("arst_we", {31'd0, mem_we}, 32'd0);
    check32("arst_bus_error", {31'd0, bus_error}, 32'd0);
    check32("arst_done", {30'd0, instr_done, illegal_instr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
